// File: rtl/arbitro_serializador.sv
// Round-robin word scheduler feeding a parallel-to-serial shifter.
// One word per slot of cantidadBits clocks; comma inserted when idle.
module arbitro_serializador #(
  parameter int                      cantidadBits = 10,
  parameter logic [cantidadBits-1:0] PALABRA_IDLE = 10'b0011111010,
  parameter int                      MAX_RACHA    = 16
) (
  input  logic                        clk,
  input  logic                        reset_L,
  input  logic                        habilitar,
  input  logic [3:0]                  valido,
  input  logic [4*cantidadBits-1:0]   datos,
  output logic [3:0]                  ack,
  output logic [cantidadBits-1:0]     palabra,
  output logic                        carga,
  output logic [1:0]                  fuente,
  output logic                        es_idle
);

  localparam int CW = (cantidadBits > 1) ? $clog2(cantidadBits) : 1;
  localparam int RW = $clog2(MAX_RACHA + 1);

  localparam logic [CW-1:0] CNT_FIN   = CW'(cantidadBits - 1);
  localparam logic [RW-1:0] RACHA_FIN = RW'(MAX_RACHA);

  logic [CW-1:0] r_contador;
  logic [1:0]    r_puntero;
  logic [RW-1:0] r_racha;

  logic                    w_fin_slot;
  logic                    w_hay;
  logic [1:0]              w_k;
  logic [1:0]              w_idx;
  logic                    w_idle;
  logic [cantidadBits-1:0] w_palabra_k;

  assign w_fin_slot = (r_contador == CNT_FIN);

  // Walk from the farthest offset down so the closest set bit wins.
  always_comb begin
    w_hay = 1'b0;
    w_k   = 2'd0;
    w_idx = 2'd0;
    for (int j = 3; j >= 0; j--) begin
      w_idx = r_puntero + 2'(j);
      if (valido[w_idx]) begin
        w_hay = 1'b1;
        w_k   = w_idx;
      end
    end
  end

  assign w_palabra_k = datos[int'(w_k)*cantidadBits +: cantidadBits];

  assign w_idle = !habilitar || (r_racha == RACHA_FIN) || !w_hay;

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      r_contador <= '0;
      r_puntero  <= 2'd0;
      r_racha    <= '0;
      palabra    <= PALABRA_IDLE;
      carga      <= 1'b0;
      ack        <= 4'd0;
      fuente     <= 2'd0;
      es_idle    <= 1'b1;
    end else begin
      carga <= 1'b0;
      ack   <= 4'd0;
      if (w_fin_slot) begin
        r_contador <= '0;
        carga      <= 1'b1;
        unique case (1'b1)
          w_idle: begin
            palabra <= PALABRA_IDLE;
            fuente  <= 2'd0;
            es_idle <= 1'b1;
            r_racha <= '0;
          end
          default: begin
            palabra   <= w_palabra_k;
            fuente    <= w_k;
            es_idle   <= 1'b0;
            ack       <= 4'b0001 << w_k;
            r_puntero <= w_k + 2'd1;
            r_racha   <= r_racha + RW'(1);
          end
        endcase
      end else begin
        r_contador <= r_contador + CW'(1);
      end
    end
  end

endmodule

// File: doc/arbitro_serializador.md
# arbitro_serializador

Round-robin scheduler that feeds the 10-bit parallel-to-serial shifter from four independent word sources. Once per serial word slot (every `cantidadBits` clocks) it picks one source, presents its word with a one-cycle load strobe and acknowledges that source. It inserts the idle/comma symbol when no source is ready, when the block is disabled, or after a run of data words reaches the configured limit. It sits directly upstream of the serializer, on the same clock.

## Interface

**Parameters**
- `cantidadBits`, default 10: word width, which is also the slot length in clocks.
- `PALABRA_IDLE`, default 10'b0011111010: comma/idle symbol (K28.5, RD−).
- `MAX_RACHA`, default 16: maximum consecutive data words before a forced idle. Must be ≥1.

**Ports**

Clock and reset are one clock and a synchronous, active-low reset.
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset_L` in 1: synchronous, active-low reset.

Other ports:
- `habilitar` in 1: when 0, every slot carries `PALABRA_IDLE` and no acks are issued.
- `valido` in 4: bit i high means source i holds a word ready.
- `datos` in 4·cantidadBits: source i word at `[i*cantidadBits +: cantidadBits]`.
- `ack` out 4: one-hot, one-cycle pulse; source i's word was consumed.
- `palabra` out cantidadBits: word for the serializer, registered.
- `carga` out 1: one-cycle load strobe for the serializer.
- `fuente` out 2: index of the source that supplied `palabra` (0 on idle slots).
- `es_idle` out 1: high when `palabra` is the idle symbol for this slot.

## Operation

**Reset** (`reset_L`=0 at an edge):
- `contador`=0, `puntero`=0, `racha`=0.
- `palabra`=`PALABRA_IDLE`, `carga`=0, `ack`=0, `fuente`=0, `es_idle`=1.
- Reset mid-slot aborts the slot. No ack is issued, so the source keeps its word.

**Slot counter:**
- Each non-reset edge: if `contador`==cantidadBits−1, then `contador`←0 and a *slot event* occurs; otherwise `contador`←`contador`+1.

**Slot event decision**, evaluated on the current-cycle inputs, first match wins:
1. `habilitar`=0 → idle slot.
2. `racha`==`MAX_RACHA` → forced idle slot.
3. Search `valido` starting at `puntero`, in order `puntero`, +1, +2, +3 (mod 4). The first set bit k → data slot from source k.
4. No `valido` bit set → idle slot.

**Data slot from source k:**
- `palabra`←source k word; `fuente`←k; `es_idle`←0.
- `ack[k]`←1; `puntero`←(k+1) mod 4; `racha`←`racha`+1.

**Idle slot:**
- `palabra`←`PALABRA_IDLE`; `fuente`←0; `es_idle`←1.
- `ack`←0; `racha`←0; `puntero` unchanged.

**Every slot event:** `carga`←1.

**All other edges:** `carga`←0 and `ack`←0. `palabra`, `fuente` and `es_idle` hold their values.

**Source contract:**
- A source holds `datos` and `valido` stable until it sees `ack`.
- It may drop `valido` or change its word in the cycle after `ack`.
- `valido` changing mid-slot is legal; only the value at the slot-event edge matters.

## Timing

- Slot period: exactly cantidadBits clocks. `carga` is high 1 cycle in every cantidadBits.
- First `carga` after reset: asserted in the cycle following the cantidadBits-th rising edge with `reset_L`=1.
- Latency: `valido`/`datos` sampled at a slot-event edge appear on `palabra` in the next cycle, together with `carga` and `ack`.
- The serializer loads `palabra` on the edge at which `carga`=1.
- `ack` and `carga` are coincident, and `ack` is never high without `carga`.
- Fairness: with all four sources valid, the grant order is 0,1,2,3,0,… A source waits at most 3 data slots plus 1 forced idle.
- A comma is guaranteed at least every `MAX_RACHA`+1 slots.

## Test plan

- **Reset then idle:** reset_L=0 for 3 cycles, then valido=0 for 40 cycles → `carga` pulses at cycles 10, 20, 30, 40 after release; `palabra`=10'b0011111010; `es_idle`=1; `ack`=0.
- **Single source:** valido=4'b0100, source 2 word=10'h155, held until ack → at the next slot `palabra`=10'h155, `fuente`=2, `ack`=4'b0100 coincident with `carga`. Drop valido afterwards → the following slot is idle.
- **Round robin:** all valid with words 10'h001..10'h004, refreshed after each ack → slots carry sources 0,1,2,3,0,1… Starting from `puntero`=2 with sources 0 and 3 valid → order 3, then 0.
- **Forced comma:** MAX_RACHA=3, all sources continuously valid → data, data, data, idle, data…; no ack in the idle slot; the grant after the idle resumes at the next `puntero`.
- **Disable:** `habilitar`=0 for 2 slots with valido=4'hF → 2 idle slots with no ack. Re-enable → service resumes at the unchanged `puntero`.
- **Reset mid-slot:** reset_L=0 at `contador`=5 with source 1 valid → no ack and outputs at reset values. After release, the first `carga` comes 10 cycles later and carries source 1's word.
